// File: rtl/pcs_sync_param.sv
// 1000BASE-X style code-group synchronisation: comma alignment, error accounting and SUDI output.
// Optional loss-of-sync event counter on port loss_count when SYNC_LOSS_CNT_EN is defined.
module pcs_sync_param #(
  parameter int unsigned COMMA_N = 3,
  parameter int unsigned ERR_N   = 4,
  parameter int unsigned GOOD_N  = 4
) (
  input  logic        Clk,
  input  logic        mr_main_reset,
  input  logic [9:0]  PUDI,
  input  logic        PUDI_indicate,
  output logic        code_sync_status,
  output logic [10:0] SUDI,
  output logic        SUDI_indicate
`ifdef SYNC_LOSS_CNT_EN
  ,
  output logic [7:0]  loss_count
`endif
);

  localparam int unsigned CW = 3;
  localparam int unsigned EW = 3;
  localparam int unsigned GW = 4;
  localparam int unsigned LW = 8;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    SYNC_ACQUIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          rx_even_q, rx_even_d;
  logic [10:0]   sudi_q, sudi_d;
  logic          sudi_ind_q, sudi_ind_d;
  logic          sync_q, sync_d;

  logic [3:0]    ones_c;
  logic          run_c;
  logic          comma_c;
  logic          invalid_c;
  logic          aligned_comma_c;
  logic          err_event_c;
  logic [CW-1:0] comma_inc_c;
  logic [EW-1:0] err_inc_c;
  logic [GW-1:0] good_inc_c;

  // Code-group classification: disparity (ones count) and run-length checks
  always_comb begin
    ones_c = '0;
    for (int i = 0; i < 10; i++) begin
      ones_c = ones_c + 4'(PUDI[i]);
    end
    run_c = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      if ((PUDI[i+:5] == 5'b11111) || (PUDI[i+:5] == 5'b00000)) begin
        run_c = 1'b1;
      end
    end
  end

  assign comma_c         = (PUDI[9:3] == 7'b0011111) || (PUDI[9:3] == 7'b1100000);
  assign invalid_c       = (ones_c < 4'd4) || (ones_c > 4'd6) || (run_c && !comma_c);
  assign aligned_comma_c = comma_c && !rx_even_q;
  assign err_event_c     = invalid_c || (comma_c && rx_even_q);

  assign comma_inc_c = comma_cnt_q + CW'(1);
  assign err_inc_c   = err_cnt_q + EW'(1);
  assign good_inc_c  = (good_cnt_q == GW'(GOOD_N)) ? good_cnt_q : good_cnt_q + GW'(1);

  // State register
  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q <= LOSS_OF_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (PUDI_indicate) begin
      case (state_q)
        LOSS_OF_SYNC: begin
          if (comma_c) begin
            if (COMMA_N == 1) begin
              state_d     = SYNC_ACQUIRED;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              state_d     = COMMA_DETECT;
              comma_cnt_d = CW'(1);
            end
          end
        end
        COMMA_DETECT: begin
          if (err_event_c) begin
            state_d     = LOSS_OF_SYNC;
            comma_cnt_d = '0;
          end else if (aligned_comma_c) begin
            if (comma_inc_c == CW'(COMMA_N)) begin
              state_d     = SYNC_ACQUIRED;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              comma_cnt_d = comma_inc_c;
            end
          end
        end
        SYNC_ACQUIRED: begin
          if (err_event_c) begin
            if (err_inc_c == EW'(ERR_N)) begin
              state_d     = LOSS_OF_SYNC;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end else begin
              err_cnt_d  = err_inc_c;
              good_cnt_d = '0;
            end
          end else if ((good_inc_c == GW'(GOOD_N)) && (err_cnt_q != '0)) begin
            err_cnt_d  = err_cnt_q - EW'(1);
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc_c;
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    rx_even_d  = rx_even_q;
    sudi_d     = sudi_q;
    sudi_ind_d = 1'b0;
    sync_d     = (state_d == SYNC_ACQUIRED);
    if (PUDI_indicate) begin
      rx_even_d  = aligned_comma_c ? 1'b1 : !rx_even_q;
      sudi_d     = {rx_even_d, PUDI};
      sudi_ind_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      rx_even_q   <= 1'b0;
      sudi_q      <= '0;
      sudi_ind_q  <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rx_even_q   <= rx_even_d;
      sudi_q      <= sudi_d;
      sudi_ind_q  <= sudi_ind_d;
      sync_q      <= sync_d;
    end
  end

  assign code_sync_status = sync_q;
  assign SUDI             = sudi_q;
  assign SUDI_indicate    = sudi_ind_q;

`ifdef SYNC_LOSS_CNT_EN
  logic [LW-1:0] loss_q, loss_d;

  // Saturating count of drops out of sync
  always_comb begin
    loss_d = loss_q;
    if ((state_q == SYNC_ACQUIRED) && (state_d == LOSS_OF_SYNC) && (loss_q != {LW{1'b1}})) begin
      loss_d = loss_q + LW'(1);
    end
  end

  always_ff @(posedge Clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pcs_sync_param.sv
// Directed bench for pcs_sync_param: acquisition, loss, error recovery, misalignment, async reset, idle hold.
module tb_pcs_sync_param;

  localparam logic [9:0] K   = 10'b0011111010;
  localparam logic [9:0] D   = 10'b1001000101;
  localparam logic [9:0] INV = 10'b1111111111;

  logic        Clk;
  logic        mr_main_reset;
  logic [9:0]  PUDI;
  logic        PUDI_indicate;
  logic        code_sync_status;
  logic [10:0] SUDI;
  logic        SUDI_indicate;
`ifdef SYNC_LOSS_CNT_EN
  logic [7:0]  loss_count;
`endif

  int vectors;
  int miscompares;

  pcs_sync_param dut (
    .Clk              (Clk),
    .mr_main_reset    (mr_main_reset),
    .PUDI             (PUDI),
    .PUDI_indicate    (PUDI_indicate),
    .code_sync_status (code_sync_status),
    .SUDI             (SUDI),
    .SUDI_indicate    (SUDI_indicate)
`ifdef SYNC_LOSS_CNT_EN
    ,
    .loss_count       (loss_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Present one code group for exactly one rising edge; returns 1 time unit after that edge
  task automatic send(input logic [9:0] g);
    @(negedge Clk);
    PUDI          = g;
    PUDI_indicate = 1'b1;
    @(posedge Clk);
    #1;
    PUDI_indicate = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    mr_main_reset = 1'b0;
    PUDI_indicate = 1'b0;
    @(negedge Clk);
    mr_main_reset = 1'b1;
  endtask

  task automatic acquire();
    send(K); send(D); send(K); send(D); send(K);
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b0;
    PUDI          = INV;
    PUDI_indicate = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sync: got %b expected 0", code_sync_status);
    end
    vectors++;
    if (SUDI !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_sudi: got %h expected 000", SUDI);
    end
    vectors++;
    if (SUDI_indicate !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sudi_ind: got %b expected 0", SUDI_indicate);
    end
`ifdef SYNC_LOSS_CNT_EN
    vectors++;
    if (loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_loss_count: got %0d expected 0", loss_count);
    end
`endif
    PUDI_indicate = 1'b0;
  endtask

  task automatic test_acquire();
    logic [9:0] seq    [5];
    logic       exp_sy [5];
    logic       exp_rx [5];
    seq    = '{K, D, K, D, K};
    exp_sy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rx = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      vectors++;
      if (code_sync_status !== exp_sy[i]) begin
        miscompares++;
        $display("FAIL acquire_sync[%0d]: got %b expected %b", i, code_sync_status, exp_sy[i]);
      end
      vectors++;
      if (SUDI !== {exp_rx[i], seq[i]}) begin
        miscompares++;
        $display("FAIL acquire_sudi[%0d]: got %h expected %h", i, SUDI, {exp_rx[i], seq[i]});
      end
      vectors++;
      if (SUDI_indicate !== 1'b1) begin
        miscompares++;
        $display("FAIL acquire_sudi_ind[%0d]: got %b expected 1", i, SUDI_indicate);
      end
    end
    @(posedge Clk);
    #1;
    vectors++;
    if (SUDI_indicate !== 1'b0) begin
      miscompares++;
      $display("FAIL acquire_strobe_drop: got %b expected 0", SUDI_indicate);
    end
  endtask

  task automatic test_loss();
    logic [9:0] seq    [7];
    logic       exp_sy [7];
    seq    = '{INV, D, INV, D, INV, D, INV};
    exp_sy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    acquire();
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      vectors++;
      if (code_sync_status !== exp_sy[i]) begin
        miscompares++;
        $display("FAIL loss_sync[%0d]: got %b expected %b", i, code_sync_status, exp_sy[i]);
      end
    end
`ifdef SYNC_LOSS_CNT_EN
    vectors++;
    if (loss_count !== 8'd1) begin
      miscompares++;
      $display("FAIL loss_count: got %0d expected 1", loss_count);
    end
`endif
  endtask

  task automatic test_recover();
    do_reset();
    acquire();
    for (int i = 0; i < 18; i++) begin
      send((i < 3 || i >= 15) ? INV : D);
      vectors++;
      if (code_sync_status !== 1'b1) begin
        miscompares++;
        $display("FAIL recover_hold[%0d]: got %b expected 1", i, code_sync_status);
      end
    end
    send(INV);
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL recover_fourth_err: got %b expected 0", code_sync_status);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    send(K); send(D); send(K);
    send(K);
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_sync: got %b expected 0", code_sync_status);
    end
    vectors++;
    if (SUDI !== {1'b0, K}) begin
      miscompares++;
      $display("FAIL misalign_sudi: got %h expected %h", SUDI, {1'b0, K});
    end
    send(K); send(D); send(K);
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_restart_two: got %b expected 0", code_sync_status);
    end
    send(D); send(K);
    vectors++;
    if (code_sync_status !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_restart_three: got %b expected 1", code_sync_status);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    acquire();
    send(D);
    #1;
    vectors++;
    if ({code_sync_status, SUDI_indicate, SUDI} !== {1'b1, 1'b1, 1'b0, D}) begin
      miscompares++;
      $display("FAIL async_pre: got %b_%b_%h expected 1_1_%h",
               code_sync_status, SUDI_indicate, SUDI, {1'b0, D});
    end
    mr_main_reset = 1'b0;
    #1;
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL async_sync: got %b expected 0", code_sync_status);
    end
    vectors++;
    if (SUDI !== 11'h000) begin
      miscompares++;
      $display("FAIL async_sudi: got %h expected 000", SUDI);
    end
    vectors++;
    if (SUDI_indicate !== 1'b0) begin
      miscompares++;
      $display("FAIL async_sudi_ind: got %b expected 0", SUDI_indicate);
    end
    @(negedge Clk);
    mr_main_reset = 1'b1;
    send(K); send(D); send(K); send(D);
    vectors++;
    if (code_sync_status !== 1'b0) begin
      miscompares++;
      $display("FAIL async_restart_early: got %b expected 0", code_sync_status);
    end
    send(K);
    vectors++;
    if (code_sync_status !== 1'b1) begin
      miscompares++;
      $display("FAIL async_restart_sync: got %b expected 1", code_sync_status);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    acquire();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      PUDI          = INV;
      PUDI_indicate = 1'b0;
      @(posedge Clk);
      #1;
      vectors++;
      if ({code_sync_status, SUDI_indicate, SUDI} !== {1'b1, 1'b0, 1'b1, K}) begin
        miscompares++;
        $display("FAIL idle_hold[%0d]: got %b_%b_%h expected 1_0_%h",
                 i, code_sync_status, SUDI_indicate, SUDI, {1'b1, K});
      end
    end
    send(D);
    vectors++;
    if ({code_sync_status, SUDI_indicate, SUDI} !== {1'b1, 1'b1, 1'b0, D}) begin
      miscompares++;
      $display("FAIL idle_resume: got %b_%b_%h expected 1_1_%h",
               code_sync_status, SUDI_indicate, SUDI, {1'b0, D});
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    mr_main_reset = 1'b0;
    PUDI          = '0;
    PUDI_indicate = 1'b0;
    test_reset();
    test_acquire();
    test_loss();
    test_recover();
    test_misaligned();
    test_async_reset();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
